eth_frame_patch_tx: RTL and testbench

//  Multi-lane, multi-patch successor of the single-byte loop TX stage.
//  - Forwards one frame per descriptor from S_AXIS_FRAME to M_AXIS.
//  - Overwrites up to N_PATCH 16-bit fields (checksums, lengths) at byte offsets given in the descriptor.
//  - Sits between the loop frame buffer and the MAC TX adapter. Adds no latency.

---
 rtl/eth_frame_patch_tx.sv | 204 ++++++++++++++++++++
 tb/tb_eth_frame_patch_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_patch_tx.sv
// eth_frame_patch_tx
// Forwards one frame per accepted descriptor from the frame source to the
// MAC-side stream with zero added latency, overwriting up to N_PATCH 16-bit
// fields (little-endian byte pairs) at descriptor-supplied even byte offsets.
// Handshake flow: IDLE waits for a descriptor, TX streams beats until tlast.
module eth_frame_patch_tx #(
  parameter int DATA_BYTES = 1,
  parameter int N_PATCH    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [8*DATA_BYTES-1:0] s_axis_frame_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_frame_tkeep,
  input  logic                    s_axis_frame_tuser,
  input  logic                    s_axis_frame_tlast,
  input  logic                    s_axis_frame_tvalid,
  output logic                    s_axis_frame_tready,
  input  logic [32*N_PATCH-1:0]   s_axis_desc_tdata,
  input  logic                    s_axis_desc_tvalid,
  output logic                    s_axis_desc_tready,
  output logic [31:0]             frame_count
);

  // Patch position addresses 16-bit words, so it is one bit narrower than the byte counter.
  localparam int PW = CNT_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   CNT_STEP = (CNT_W + 1)'(DATA_BYTES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    desc_tready_r;
  logic [CNT_W-1:0]        byte_cnt_r;
  logic [N_PATCH-1:0]      en_r;
  logic [N_PATCH*PW-1:0]   pos_r;
  logic [N_PATCH*16-1:0]   value_r;
  logic [31:0]             frame_count_r;

  logic                    desc_fire_s;
  logic                    beat_fire_s;
  logic                    last_fire_s;
  logic [CNT_W:0]          cnt_sum_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    cnt_sat_s;

  // Replacement byte for one lane: the lowest enabled, non-zero slot whose word
  // address matches wins; addresses past the counter range never match.
  function automatic logic [7:0] patch_byte(
    input logic [CNT_W-1:0]      cnt,
    input int                    lane,
    input logic [7:0]            din,
    input logic [N_PATCH-1:0]    en,
    input logic [N_PATCH*PW-1:0] pos,
    input logic [N_PATCH*16-1:0] val
  );
    logic [CNT_W:0] addr;
    logic           hit;
    logic [7:0]     res;
    addr = {1'b0, cnt} + (CNT_W + 1)'(lane);
    res  = din;
    for (int k = N_PATCH - 1; k >= 0; k--) begin
      hit = en[k] & (val[16*k +: 16] != 16'h0000) & ~addr[CNT_W] &
            (addr[CNT_W-1:1] == pos[PW*k +: PW]);
      res = hit ? (addr[0] ? val[16*k+8 +: 8] : val[16*k +: 8]) : res;
    end
    return res;
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus the handshake gating of the frame path.
  always_comb begin
    state_s             = state_r;
    m_axis_tvalid       = 1'b0;
    s_axis_frame_tready = 1'b0;
    desc_fire_s         = 1'b0;
    beat_fire_s         = 1'b0;
    last_fire_s         = 1'b0;
    case (state_r)
      IDLE: begin
        desc_fire_s = s_axis_desc_tvalid & desc_tready_r;
        if (desc_fire_s) begin
          state_s = TX;
        end else begin
          state_s = IDLE;
        end
      end
      TX: begin
        m_axis_tvalid       = s_axis_frame_tvalid;
        s_axis_frame_tready = m_axis_tready;
        beat_fire_s         = s_axis_frame_tvalid & m_axis_tready;
        last_fire_s         = beat_fire_s & s_axis_frame_tlast;
        if (last_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = TX;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Descriptor ready: low in reset and during a frame, high otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      desc_tready_r <= 1'b0;
    end else if (desc_fire_s) begin
      desc_tready_r <= 1'b0;
    end else if (last_fire_s) begin
      desc_tready_r <= 1'b1;
    end else if (state_r == IDLE) begin
      desc_tready_r <= 1'b1;
    end else begin
      desc_tready_r <= desc_tready_r;
    end
  end

  // Latch every patch slot of the accepted descriptor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_r    <= {N_PATCH{1'b0}};
      pos_r   <= {(N_PATCH*PW){1'b0}};
      value_r <= {(N_PATCH*16){1'b0}};
    end else if (desc_fire_s) begin
      for (int k = 0; k < N_PATCH; k++) begin
        en_r[k]              <= s_axis_desc_tdata[32*k];
        pos_r[PW*k +: PW]    <= s_axis_desc_tdata[32*k+1 +: PW];
        value_r[16*k +: 16]  <= s_axis_desc_tdata[32*k+16 +: 16];
      end
    end else begin
      en_r    <= en_r;
      pos_r   <= pos_r;
      value_r <= value_r;
    end
  end

  // Saturating increment of the byte offset of the current beat.
  always_comb begin
    cnt_sum_s  = {1'b0, byte_cnt_r} + CNT_STEP;
    cnt_next_s = cnt_sum_s[CNT_W] ? CNT_MAX : cnt_sum_s[CNT_W-1:0];
    cnt_sat_s  = (byte_cnt_r == CNT_MAX);
  end

  // Byte offset of the first lane of the beat currently presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_r <= {CNT_W{1'b0}};
    end else if (desc_fire_s) begin
      byte_cnt_r <= {CNT_W{1'b0}};
    end else if (beat_fire_s && !s_axis_frame_tlast) begin
      byte_cnt_r <= cnt_next_s;
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Completed-frame counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count_r <= 32'd0;
    end else if (last_fire_s) begin
      frame_count_r <= frame_count_r + 32'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  // Per-lane patch mux; a saturated counter disables all patching.
  always_comb begin
    m_axis_tdata = s_axis_frame_tdata;
    for (int b = 0; b < DATA_BYTES; b++) begin
      m_axis_tdata[8*b +: 8] = cnt_sat_s ? s_axis_frame_tdata[8*b +: 8] :
                               patch_byte(byte_cnt_r, b, s_axis_frame_tdata[8*b +: 8],
                                          en_r, pos_r, value_r);
    end
  end

  assign m_axis_tkeep       = s_axis_frame_tkeep;
  assign m_axis_tuser       = s_axis_frame_tuser;
  assign m_axis_tlast       = s_axis_frame_tlast;
  assign s_axis_desc_tready = desc_tready_r;
  assign frame_count        = frame_count_r;

endmodule

// File: tb/tb_eth_frame_patch_tx.sv
// Bench for eth_frame_patch_tx: three instances (1, 4 and 8 bytes per beat)
// share clock, reset and stimulus buses; one is selected at a time.
module tb_eth_frame_patch_tx;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tuser;
  logic        s_tlast;
  logic [2:0]  s_tvalid;
  logic        m_tready;
  logic [63:0] desc_data;
  logic [2:0]  desc_valid;

  logic [7:0]  d1_data;  logic [0:0] d1_keep;
  logic [31:0] d4_data;  logic [3:0] d4_keep;
  logic [63:0] d8_data;  logic [7:0] d8_keep;
  logic [2:0]  o_user_v, o_last_v, o_valid_v, o_sready_v, o_dready_v;
  logic [31:0] d1_fc, d4_fc, d8_fc;

  int          bsel;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_user, o_last, o_valid, o_sready, o_dready;
  logic [31:0] o_fc;

  logic [7:0]  fdata [8][256];
  logic [7:0]  rx    [8][256];
  int          flen  [8];
  logic [63:0] fdesc [8];
  logic        fuser [8];
  int          exp_fc [3];
  int          errors = 0;
  int          checks = 0;

  eth_frame_patch_tx #(.DATA_BYTES(1), .N_PATCH(2), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .m_axis_tdata(d1_data), .m_axis_tkeep(d1_keep), .m_axis_tuser(o_user_v[0]),
    .m_axis_tlast(o_last_v[0]), .m_axis_tvalid(o_valid_v[0]), .m_axis_tready(m_tready),
    .s_axis_frame_tdata(s_tdata[7:0]), .s_axis_frame_tkeep(s_tkeep[0:0]),
    .s_axis_frame_tuser(s_tuser), .s_axis_frame_tlast(s_tlast),
    .s_axis_frame_tvalid(s_tvalid[0]), .s_axis_frame_tready(o_sready_v[0]),
    .s_axis_desc_tdata(desc_data), .s_axis_desc_tvalid(desc_valid[0]),
    .s_axis_desc_tready(o_dready_v[0]), .frame_count(d1_fc));

  eth_frame_patch_tx #(.DATA_BYTES(4), .N_PATCH(2), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .m_axis_tdata(d4_data), .m_axis_tkeep(d4_keep), .m_axis_tuser(o_user_v[1]),
    .m_axis_tlast(o_last_v[1]), .m_axis_tvalid(o_valid_v[1]), .m_axis_tready(m_tready),
    .s_axis_frame_tdata(s_tdata[31:0]), .s_axis_frame_tkeep(s_tkeep[3:0]),
    .s_axis_frame_tuser(s_tuser), .s_axis_frame_tlast(s_tlast),
    .s_axis_frame_tvalid(s_tvalid[1]), .s_axis_frame_tready(o_sready_v[1]),
    .s_axis_desc_tdata(desc_data), .s_axis_desc_tvalid(desc_valid[1]),
    .s_axis_desc_tready(o_dready_v[1]), .frame_count(d4_fc));

  eth_frame_patch_tx #(.DATA_BYTES(8), .N_PATCH(2), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .m_axis_tdata(d8_data), .m_axis_tkeep(d8_keep), .m_axis_tuser(o_user_v[2]),
    .m_axis_tlast(o_last_v[2]), .m_axis_tvalid(o_valid_v[2]), .m_axis_tready(m_tready),
    .s_axis_frame_tdata(s_tdata), .s_axis_frame_tkeep(s_tkeep),
    .s_axis_frame_tuser(s_tuser), .s_axis_frame_tlast(s_tlast),
    .s_axis_frame_tvalid(s_tvalid[2]), .s_axis_frame_tready(o_sready_v[2]),
    .s_axis_desc_tdata(desc_data), .s_axis_desc_tvalid(desc_valid[2]),
    .s_axis_desc_tready(o_dready_v[2]), .frame_count(d8_fc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Route the selected instance onto the observation signals.
  always_comb begin
    case (bsel)
      0:       begin o_data = {56'd0, d1_data}; o_keep = {7'd0, d1_keep}; o_fc = d1_fc; end
      1:       begin o_data = {32'd0, d4_data}; o_keep = {4'd0, d4_keep}; o_fc = d4_fc; end
      default: begin o_data = d8_data;          o_keep = d8_keep;          o_fc = d8_fc; end
    endcase
    o_user   = o_user_v[bsel];
    o_last   = o_last_v[bsel];
    o_valid  = o_valid_v[bsel];
    o_sready = o_sready_v[bsel];
    o_dready = o_dready_v[bsel];
  end

  function automatic logic [31:0] slot(input logic [15:0] v, input int pos, input logic en);
    return {v, 15'(pos), en};
  endfunction

  // Reference: byte i of frame f after patching, straight from the slot rules.
  function automatic logic [7:0] exp_byte(input int f, input int i);
    logic [7:0]  r;
    logic [31:0] s;
    r = fdata[f][i];
    for (int k = 1; k >= 0; k--) begin
      s = fdesc[f][32*k +: 32];
      if (s[0] && s[31:16] != 16'h0000 && (i / 2) == int'(s[15:1])) begin
        r = (i % 2 == 1) ? s[31:24] : s[23:16];
      end
    end
    return r;
  endfunction

  task automatic fill_rand(input int f, input int len);
    flen[f]  = len;
    fuser[f] = 1'($urandom_range(0, 1));
    for (int i = 0; i < len; i++) fdata[f][i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = '{0, 0, 0};
  endtask

  // Send frames first..first+nf-1 through instance sel; optional reset on a beat.
  task automatic run(input int sel, input int first, input int nf, input int rdy_pct,
                     input int rst_beat);
    int nb, f, beat, cyc, nbeats, idx;
    bit taken, want_rdy, aborted;
    logic [7:0] kexp;
    nb = (sel == 0) ? 1 : ((sel == 1) ? 4 : 8);
    f = first; beat = 0; cyc = 0; taken = 0; want_rdy = 0; aborted = 0;
    bsel = sel;
    while (f < first + nf && !aborted) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        errors++; checks++;
        $display("FAIL timeout sel=%0d frame=%0d beat=%0d", sel, f, beat);
        aborted = 1;
      end else begin
        nbeats     = (flen[f] + nb - 1) / nb;
        desc_data  = fdesc[f];
        desc_valid = taken ? 3'b000 : (3'b001 << sel);
        s_tvalid   = 3'b001 << sel;
        s_tdata    = 64'd0;
        s_tkeep    = 8'd0;
        kexp       = 8'd0;
        for (int b = 0; b < nb; b++) begin
          idx = beat * nb + b;
          s_tdata[8*b +: 8] = (idx < flen[f]) ? fdata[f][idx] : 8'(idx * 37 + f);
          s_tkeep[b] = (idx < flen[f]);
          kexp[b]    = (idx < flen[f]);
        end
        s_tlast  = (beat == nbeats - 1);
        s_tuser  = s_tlast & fuser[f];
        m_tready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        if (want_rdy) begin
          checks++;
          if (o_dready !== 1'b1) begin
            errors++; $display("FAIL desc_tready_after_tlast sel=%0d got=%b want=1", sel, o_dready);
          end
          want_rdy = 0;
        end
        if (!taken) begin
          checks++;
          if (o_valid !== 1'b0 || o_sready !== 1'b0) begin
            errors++;
            $display("FAIL idle_gating sel=%0d tvalid=%b tready=%b want 0/0", sel, o_valid, o_sready);
          end
          if (o_dready === 1'b1) taken = 1;
        end else if (rst_beat >= 0 && beat == rst_beat) begin
          rst_n    = 1'b0;
          m_tready = 1'b1;
          @(negedge clk);
          #1;
          checks++;
          if (o_valid !== 1'b0 || o_sready !== 1'b0 || o_fc !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_frame tvalid=%b tready=%b fc=%0d want 0/0/0",
                     o_valid, o_sready, o_fc);
          end
          rst_n  = 1'b1;
          exp_fc = '{0, 0, 0};
          aborted = 1;
        end else begin
          checks++;
          if (o_valid !== 1'b1 || o_sready !== m_tready) begin
            errors++;
            $display("FAIL tx_handshake sel=%0d tvalid=%b tready=%b want 1/%b",
                     sel, o_valid, o_sready, m_tready);
          end
          if (m_tready) begin
            for (int b = 0; b < nb; b++) begin
              idx = beat * nb + b;
              if (idx < flen[f]) begin
                rx[f][idx] = o_data[8*b +: 8];
                checks++;
                if (o_data[8*b +: 8] !== exp_byte(f, idx)) begin
                  errors++;
                  $display("FAIL data sel=%0d frame=%0d byte=%0d got=%h want=%h",
                           sel, f, idx, o_data[8*b +: 8], exp_byte(f, idx));
                end
              end
            end
            checks++;
            if (o_keep !== kexp || o_last !== s_tlast || o_user !== s_tuser) begin
              errors++;
              $display("FAIL sideband sel=%0d beat=%0d keep=%h last=%b user=%b want %h/%b/%b",
                       sel, beat, o_keep, o_last, o_user, kexp, s_tlast, s_tuser);
            end
            if (beat == nbeats - 1) begin
              f++; beat = 0; taken = 0; want_rdy = 1; exp_fc[sel]++;
            end else begin
              beat++;
            end
          end
        end
      end
    end
    @(negedge clk);
    desc_valid = 3'b000;
    s_tvalid   = 3'b000;
    m_tready   = 1'b0;
    #1;
    if (!aborted) begin
      checks++;
      if (o_fc !== 32'(exp_fc[sel]) || (want_rdy && o_dready !== 1'b1)) begin
        errors++;
        $display("FAIL frame_count sel=%0d got=%0d want=%0d dready=%b", sel, o_fc, exp_fc[sel], o_dready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tuser = 1'b0; s_tlast = 1'b0;
    s_tvalid = 3'b111; m_tready = 1'b1; desc_data = 64'd0; desc_valid = 3'b111;
    exp_fc = '{0, 0, 0};
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      bsel = s;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_sready !== 1'b0 || o_dready !== 1'b0 || o_fc !== 32'd0) begin
        errors++;
        $display("FAIL reset_state sel=%0d tvalid=%b tready=%b dready=%b fc=%0d want 0/0/0/0",
                 s, o_valid, o_sready, o_dready, o_fc);
      end
    end
    s_tvalid = 3'b000; desc_valid = 3'b000;
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      bsel = s;
      #1;
      checks++;
      if (o_dready !== 1'b1) begin
        errors++; $display("FAIL desc_ready_after_reset sel=%0d got=%b want=1", s, o_dready);
      end
    end
  endtask

  task automatic test_single_lane();
    flen[0] = 64; fuser[0] = 1'b1;
    for (int i = 0; i < 64; i++) fdata[0][i] = 8'(i);
    fdesc[0] = {slot(16'h0000, 0, 1'b0), slot(16'hBEEF, 12, 1'b1)};
    run(0, 0, 1, 100, -1);
    checks++;
    if (rx[0][24] !== 8'hEF || rx[0][25] !== 8'hBE || rx[0][23] !== 8'd23 || rx[0][26] !== 8'd26) begin
      errors++;
      $display("FAIL beef_patch bytes23..26=%h %h %h %h want 17 ef be 1a",
               rx[0][23], rx[0][24], rx[0][25], rx[0][26]);
    end
  endtask

  task automatic test_multi_lane();
    logic [15:0] v0, v1;
    v0 = 16'($urandom_range(1, 65535));
    v1 = 16'($urandom_range(1, 65535));
    fill_rand(1, 40);
    fdesc[1] = {slot(v1, 17, 1'b1), slot(v0, 5, 1'b1)};
    run(1, 1, 1, 100, -1);
    checks++;
    if ({rx[1][11], rx[1][10]} !== v0 || {rx[1][35], rx[1][34]} !== v1) begin
      errors++;
      $display("FAIL multi_lane got=%h%h/%h%h want=%h/%h",
               rx[1][11], rx[1][10], rx[1][35], rx[1][34], v0, v1);
    end
  endtask

  task automatic test_overlap();
    fill_rand(2, 16);
    fdesc[2] = {slot(16'h2222, 3, 1'b1), slot(16'h1111, 3, 1'b1)};
    run(1, 2, 1, 70, -1);
    checks++;
    if (rx[2][6] !== 8'h11 || rx[2][7] !== 8'h11) begin
      errors++; $display("FAIL overlap got=%h %h want=11 11", rx[2][6], rx[2][7]);
    end
  endtask

  task automatic test_no_patch();
    int diff;
    fill_rand(3, 60);
    fill_rand(4, 60);
    fdesc[3] = {slot(16'($urandom_range(1, 65535)), 5, 1'b0), slot(16'h0000, 2, 1'b1)};
    fdesc[4] = {slot(16'h0000, 0, 1'b0), slot(16'($urandom_range(1, 65535)), 40, 1'b1)};
    run(2, 3, 2, 60, -1);
    for (int f = 3; f < 5; f++) begin
      diff = 0;
      for (int i = 0; i < 60; i++) if (rx[f][i] !== fdata[f][i]) diff++;
      checks++;
      if (diff != 0) begin
        errors++; $display("FAIL unmodified frame=%0d changed_bytes=%0d want=0", f, diff);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [2];
    pulse_reset();
    for (int f = 5; f < 8; f++) begin
      fill_rand(f, $urandom_range(1, 50));
      for (int k = 0; k < 2; k++)
        v[k] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      fdesc[f] = {slot(v[1], $urandom_range(0, 26), 1'($urandom_range(0, 1))),
                  slot(v[0], $urandom_range(0, 26), 1'($urandom_range(0, 1)))};
    end
    run(1, 5, 3, 50, -1);
    checks++;
    if (d4_fc !== 32'd3) begin
      errors++; $display("FAIL burst_frame_count got=%0d want=3", d4_fc);
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_rand(5, 48);
    fdesc[5] = {slot(16'h0000, 0, 1'b0), slot(16'hA5C3, 20, 1'b1)};
    run(1, 5, 1, 100, 3);
    fill_rand(6, 30);
    fdesc[6] = {slot(16'h7E81, 1, 1'b1), slot(16'h1234, 7, 1'b1)};
    run(1, 6, 1, 100, -1);
    checks++;
    if ({rx[6][15], rx[6][14]} !== 16'h1234 || {rx[6][3], rx[6][2]} !== 16'h7E81) begin
      errors++;
      $display("FAIL after_reset_patch got=%h%h/%h%h want=1234/7e81",
               rx[6][15], rx[6][14], rx[6][3], rx[6][2]);
    end
  endtask

  initial begin
    bsel = 0;
    test_reset();
    test_single_lane();
    test_multi_lane();
    test_overlap();
    test_no_patch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish in time");
  end

endmodule
